// File: rtl/param_shift_register.sv
// Universal WIDTH-bit shift/rotate/load register with a burst engine.
// A burst latches a shift/rotate mode and count, then runs it autonomously.
module param_shift_register #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             x_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] sr_o,
  output logic             so_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbg_state_o
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             so_q, so_d;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_q;
  logic [2:0]       op_mode;
  logic             start_mode_ok;

  // While BUSY the latched mode drives the datapath; live mode_i is ignored.
  assign op_mode       = (state_q == BUSY) ? mode_q : mode_i;
  assign start_mode_ok = (mode_i == MODE_SHL) || (mode_i == MODE_SHR) ||
                         (mode_i == MODE_ROL) || (mode_i == MODE_ROR);

  always_comb begin
    sr_d = sr_q;
    so_d = so_q;
    case (op_mode)
      MODE_SHL: begin
        sr_d = {sr_q[WIDTH-2:0], x_i};
        so_d = sr_q[WIDTH-1];
      end
      MODE_SHR: begin
        sr_d = {x_i, sr_q[WIDTH-1:1]};
        so_d = sr_q[0];
      end
      MODE_ROL: begin
        sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        so_d = sr_q[WIDTH-1];
      end
      MODE_ROR: begin
        sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
        so_d = sr_q[0];
      end
      MODE_LOAD: sr_d = load_data_i;
      default: begin
        sr_d = sr_q;
        so_d = so_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // start_i outranks en_i, even when the start request is ignored.
          if (start_i) begin
            if (start_mode_ok) begin
              if (cnt_i != '0) begin
                state_q <= BUSY;
                mode_q  <= mode_i;
                cnt_q   <= cnt_i;
              end else begin
                done_q <= 1'b1;
              end
            end
          end else if (en_i) begin
            sr_q <= sr_d;
            so_q <= so_d;
          end
        end
        BUSY: begin
          sr_q  <= sr_d;
          so_q  <= so_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sr_o        = sr_q;
  assign so_o        = so_q;
  assign busy_o      = (state_q == BUSY);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: cycle-level reference model feeding an
// expected queue, plus directed checks of the key values from the test plan.
module tb_param_shift_register;
  localparam int W  = 4;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          en_i, x_i, start_i;
  logic [2:0]    mode_i;
  logic [W-1:0]  load_data_i;
  logic [CW-1:0] cnt_i;
  logic [W-1:0]  sr_o;
  logic          so_o, busy_o, done_o, dbg_state_o;

  always #5 clk = ~clk;

  param_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .mode_i(mode_i), .x_i(x_i),
    .load_data_i(load_data_i), .start_i(start_i), .cnt_i(cnt_i),
    .sr_o(sr_o), .so_o(so_o), .busy_o(busy_o), .done_o(done_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0] m_sr;
  logic         m_so, m_busy, m_done;
  int           m_rem;
  logic [2:0]   m_mode;

  task automatic model_clear();
    m_sr = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 3'd0;
  endtask

  task automatic model_op(input logic [2:0] md, input logic x, input logic [W-1:0] ld);
    case (md)
      3'd1: begin m_so = m_sr[W-1]; m_sr = {m_sr[W-2:0], x}; end
      3'd2: begin m_so = m_sr[0];   m_sr = {x, m_sr[W-1:1]}; end
      3'd3: begin m_so = m_sr[W-1]; m_sr = {m_sr[W-2:0], m_sr[W-1]}; end
      3'd4: begin m_so = m_sr[0];   m_sr = {m_sr[0], m_sr[W-1:1]}; end
      3'd5: m_sr = ld;
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic en, input logic [2:0] md, input logic x,
                            input logic st, input logic [CW-1:0] cnt, input logic [W-1:0] ld);
    logic nd;
    nd = 1'b0;
    if (m_busy) begin
      model_op(m_mode, x, ld);
      m_rem--;
      if (m_rem == 0) begin m_busy = 1'b0; nd = 1'b1; end
    end else if (st) begin
      if (md >= 3'd1 && md <= 3'd4) begin
        if (cnt == 0) nd = 1'b1;
        else begin m_busy = 1'b1; m_rem = int'(cnt); m_mode = md; end
      end
    end else if (en) begin
      model_op(md, x, ld);
    end
    m_done = nd;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input string tag, input logic en, input logic [2:0] md, input logic x,
                       input logic st, input logic [CW-1:0] cnt, input logic [W-1:0] ld);
    logic [W+2:0] e;
    en_i = en; mode_i = md; x_i = x; start_i = st; cnt_i = cnt; load_data_i = ld;
    model_edge(en, md, x, st, cnt, ld);
    exp_q.push_back({m_sr, m_so, m_busy, m_done});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check(tag, {sr_o, so_o, busy_o, done_o}, e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {sr_o, so_o, busy_o, done_o, dbg_state_o}, '0);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    #1;
    check_all_zero("reset_immediate");
    repeat (n) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    reset = 1'b0;
    model_clear();
  endtask

  // ---------------- stimulus ----------------
  int   busy_cnt;
  logic seen_done;
  logic [W-1:0] sr_at_done;
  logic so_at_done;
  logic [3:0] t1_x;
  logic [2:0] hold_md;

  initial begin
    reset = 1'b0; en_i = 0; mode_i = 0; x_i = 0; start_i = 0; cnt_i = 0; load_data_i = 0;
    model_clear();
    #2;

    // 1. reset, single-step shift left with x = 1,0,1,1
    apply_reset(3);
    t1_x = 4'b1101;
    for (int i = 0; i < 4; i++) cycle("t1_shl", 1'b1, 3'd1, t1_x[i], 1'b0, '0, '0);
    check("t1_sr_final", sr_o, 4'b1011);
    check("t1_so_final", so_o, 1'b0);

    // 2. parallel load then shift right
    cycle("t2_load", 1'b1, 3'd5, 1'b1, 1'b0, '0, 4'b1010);
    cycle("t2_shr0", 1'b1, 3'd2, 1'b0, 1'b0, '0, '0);
    check("t2_sr_a", {sr_o, so_o}, {4'b0101, 1'b0});
    cycle("t2_shr1", 1'b1, 3'd2, 1'b0, 1'b0, '0, '0);
    check("t2_sr_b", {sr_o, so_o}, {4'b0010, 1'b1});

    // 3. hold: en_i low, or hold/reserved codes
    for (int i = 0; i < 5; i++) begin
      case ($urandom_range(0, 3))
        0: cycle("t3_en0", 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, '0, 4'hF);
        1: cycle("t3_m0", 1'b1, 3'd0, 1'($urandom_range(0, 1)), 1'b0, '0, 4'hF);
        2: cycle("t3_m6", 1'b1, 3'd6, 1'($urandom_range(0, 1)), 1'b0, '0, 4'hF);
        default: cycle("t3_m7", 1'b1, 3'd7, 1'($urandom_range(0, 1)), 1'b0, '0, 4'hF);
      endcase
    end
    check("t3_hold", {sr_o, so_o}, {4'b0010, 1'b1});

    // 4. burst rotate left by 6 with junk on the idle-side inputs
    cycle("t4_load", 1'b1, 3'd5, 1'b0, 1'b0, '0, 4'b0001);
    busy_cnt = 0; seen_done = 1'b0; sr_at_done = '0; so_at_done = 1'b1;
    cycle("t4_start", 1'b0, 3'd3, 1'b0, 1'b1, 8'd6, '0);
    if (busy_o) busy_cnt++;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      cycle("t4_burst", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      check("t4_busy_done_excl", busy_o & done_o, 1'b0);
      if (busy_o) busy_cnt++;
      if (done_o) begin seen_done = 1'b1; sr_at_done = sr_o; so_at_done = so_o; end
    end
    check("t4_done_seen", seen_done, 1'b1);
    check("t4_busy_cycles", busy_cnt, 6);
    check("t4_sr_at_done", sr_at_done, 4'b0100);
    check("t4_so_at_done", so_at_done, 1'b0);

    // 5. zero-count burst, ignored start, start-over-en priority
    cycle("t5_zero", 1'b0, 3'd1, 1'b1, 1'b1, 8'd0, '0);
    check("t5_zero_done", {done_o, busy_o, sr_o}, {1'b1, 1'b0, 4'b0100});
    cycle("t5_idle", 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
    check("t5_done_drop", done_o, 1'b0);
    cycle("t5_start_load", 1'b1, 3'd5, 1'b0, 1'b1, 8'd3, 4'b1111);
    check("t5_ignored", {sr_o, busy_o, done_o}, {4'b0100, 1'b0, 1'b0});
    cycle("t5_prio", 1'b1, 3'd1, 1'b1, 1'b1, 8'd2, '0);
    check("t5_no_step", {sr_o, busy_o}, {4'b0100, 1'b1});
    cycle("t5_b1", 1'b1, 3'd2, 1'b1, 1'b0, '0, '0);
    cycle("t5_b2", 1'b1, 3'd2, 1'b1, 1'b0, '0, '0);
    check("t5_two_shifts", {sr_o, done_o, busy_o}, {4'b0011, 1'b1, 1'b0});
    // back-to-back start on the done cycle
    cycle("t5_restart", 1'b0, 3'd4, 1'b0, 1'b1, 8'd1, '0);
    cycle("t5_ror", 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
    check("t5_ror_result", {sr_o, so_o, done_o}, {4'b1001, 1'b1, 1'b1});

    // 6. reset mid-burst, then a fresh burst
    cycle("t6_start", 1'b0, 3'd1, 1'b1, 1'b1, 8'd10, '0);
    for (int i = 0; i < 3; i++) cycle("t6_shift", 1'b0, 3'd0, 1'b1, 1'b0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t6_abort_immediate");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("t6_abort_no_done");
    reset = 1'b0;
    model_clear();
    cycle("t6_start2", 1'b0, 3'd2, 1'b1, 1'b1, 8'd2, '0);
    cycle("t6_b1", 1'b0, 3'd0, 1'b1, 1'b0, '0, '0);
    cycle("t6_b2", 1'b0, 3'd0, 1'b1, 1'b0, '0, '0);
    check("t6_result", {sr_o, done_o, busy_o}, {4'b1100, 1'b1, 1'b0});

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
